// File: rtl/register_fetch_forward_pkg.sv
// Shared types for the operand-fetch stage: opcodes, packet layout, match helper.
// Packets are [0:PKT_W-1]: value [0:127], rt [128:134], we [135], reserved above.
package descriptions;

  typedef enum logic [7:0] {
    NOP    = 8'h00,
    OP_ADD = 8'h01,
    OP_SUB = 8'h02,
    OP_AND = 8'h03,
    OP_LQD = 8'h10,
    OP_BR  = 8'h20
  } opcode;

  localparam int NUM_REGS      = 128;
  localparam int NUM_FW_STAGES = 7;
  localparam int PKT_W         = 143;
  localparam int ADDR_W        = 7;

  localparam int PKT_VAL_LSB = 127;
  localparam int PKT_RT_MSB  = 128;
  localparam int PKT_RT_LSB  = 134;
  localparam int PKT_WE      = 135;

  function automatic logic fwd_match(
    input logic [0:PKT_W-1]  pkt,
    input logic [ADDR_W-1:0] addr
  );
    return pkt[PKT_WE] && (pkt[PKT_RT_MSB:PKT_RT_LSB] == addr);
  endfunction

endpackage

// File: rtl/register_fetch_forward_regfile.sv
// 128 x 128-bit register file: two write ports (even wins on collision),
// six asynchronous read ports, synchronous active-high clear.
module register_file_2w6r
  import descriptions::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we_ev,
  input  logic [6:0]        wa_ev,
  input  logic [127:0]      wd_ev,
  input  logic              we_op,
  input  logic [6:0]        wa_op,
  input  logic [127:0]      wd_op,
  input  logic [5:0][6:0]   raddr,
  output logic [5:0][127:0] rdata
);

  logic [127:0] mem [NUM_REGS];

  // Clear on reset; odd write first so a same-address even write lands last.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we_op) mem[wa_op] <= wd_op;
      if (we_ev) mem[wa_ev] <= wd_ev;
    end
  end

  for (genvar p = 0; p < 6; p++) begin : g_rd
    assign rdata[p] = mem[raddr[p]];
  end

endmodule

// File: rtl/register_fetch_forward.sv
// Operand fetch with hazard resolution ahead of the even/odd pipes.
// Macro REGFETCH_FWD_EN enables forwarding from fw_*_st_1..7; default is wb-only.
module register_fetch_forward
  import descriptions::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               ev_valid_in,
  input  logic               od_valid_in,
  input  opcode              ev_op_code_in,
  input  opcode              od_op_code_in,
  input  logic [6:0]         ev_ra_addr,
  input  logic [6:0]         ev_rb_addr,
  input  logic [6:0]         ev_rc_addr,
  input  logic [6:0]         od_ra_addr,
  input  logic [6:0]         od_rb_addr,
  input  logic [6:0]         od_rc_addr,
  input  logic [6:0]         ev_rt_addr_in,
  input  logic [6:0]         od_rt_addr_in,
  input  logic [0:17]        ev_imm_in,
  input  logic [0:17]        od_imm_in,
  input  logic [0:PKT_W-1]   fw_ev_st_1,
  input  logic [0:PKT_W-1]   fw_ev_st_2,
  input  logic [0:PKT_W-1]   fw_ev_st_3,
  input  logic [0:PKT_W-1]   fw_ev_st_4,
  input  logic [0:PKT_W-1]   fw_ev_st_5,
  input  logic [0:PKT_W-1]   fw_ev_st_6,
  input  logic [0:PKT_W-1]   fw_ev_st_7,
  input  logic [0:PKT_W-1]   fw_op_st_1,
  input  logic [0:PKT_W-1]   fw_op_st_2,
  input  logic [0:PKT_W-1]   fw_op_st_3,
  input  logic [0:PKT_W-1]   fw_op_st_4,
  input  logic [0:PKT_W-1]   fw_op_st_5,
  input  logic [0:PKT_W-1]   fw_op_st_6,
  input  logic [0:PKT_W-1]   fw_op_st_7,
  input  logic [0:PKT_W-1]   wb_ev,
  input  logic [0:PKT_W-1]   wb_op,
  output logic [127:0]       ev_ra,
  output logic [127:0]       ev_rb,
  output logic [127:0]       ev_rc,
  output logic [127:0]       od_ra,
  output logic [127:0]       od_rb,
  output logic [127:0]       od_rc,
  output logic [6:0]         ev_rt_addr,
  output logic [6:0]         od_rt_addr,
  output opcode              ev_op_code,
  output opcode              od_op_code,
  output logic [6:0]         ev_I7,
  output logic [9:0]         ev_I10,
  output logic [15:0]        ev_I16,
  output logic [17:0]        ev_I18,
  output logic [6:0]         od_I7,
  output logic [9:0]         od_I10,
  output logic [15:0]        od_I16,
  output logic [17:0]        od_I18,
  output logic               ev_valid,
  output logic               od_valid
);

  // Slot order: 0..2 even ra/rb/rc, 3..5 odd ra/rb/rc.
  logic [5:0][6:0]   src;
  logic [5:0][127:0] rf_rd;
  logic [5:0][127:0] opnd;

  assign src = {od_rc_addr, od_rb_addr, od_ra_addr,
                ev_rc_addr, ev_rb_addr, ev_ra_addr};

  register_file_2w6r u_rf (
    .clock (clock),
    .reset (reset),
    .we_ev (wb_ev[PKT_WE]),
    .wa_ev (wb_ev[PKT_RT_MSB:PKT_RT_LSB]),
    .wd_ev (wb_ev[0:PKT_VAL_LSB]),
    .we_op (wb_op[PKT_WE]),
    .wa_op (wb_op[PKT_RT_MSB:PKT_RT_LSB]),
    .wd_op (wb_op[0:PKT_VAL_LSB]),
    .raddr (src),
    .rdata (rf_rd)
  );

`ifdef REGFETCH_FWD_EN
  logic [0:PKT_W-1] fw_ev [NUM_FW_STAGES];
  logic [0:PKT_W-1] fw_op [NUM_FW_STAGES];

  assign fw_ev = '{fw_ev_st_1, fw_ev_st_2, fw_ev_st_3, fw_ev_st_4,
                   fw_ev_st_5, fw_ev_st_6, fw_ev_st_7};
  assign fw_op = '{fw_op_st_1, fw_op_st_2, fw_op_st_3, fw_op_st_4,
                   fw_op_st_5, fw_op_st_6, fw_op_st_7};
`endif

  // Reserved packet bits (and fw ports in the wb-only build) carry no meaning.
  logic unused_pkt_bits;
  assign unused_pkt_bits = ^{fw_ev_st_1, fw_ev_st_2, fw_ev_st_3, fw_ev_st_4,
                             fw_ev_st_5, fw_ev_st_6, fw_ev_st_7,
                             fw_op_st_1, fw_op_st_2, fw_op_st_3, fw_op_st_4,
                             fw_op_st_5, fw_op_st_6, fw_op_st_7,
                             wb_ev[136:142], wb_op[136:142]};

  // Lowest priority applied first; later matches overwrite, youngest last.
  always_comb begin
    opnd = rf_rd;
    for (int p = 0; p < 6; p++) begin
      if (fwd_match(wb_op, src[p])) opnd[p] = wb_op[0:PKT_VAL_LSB];
      if (fwd_match(wb_ev, src[p])) opnd[p] = wb_ev[0:PKT_VAL_LSB];
`ifdef REGFETCH_FWD_EN
      for (int i = NUM_FW_STAGES - 1; i >= 0; i--) begin
        if (fwd_match(fw_op[i], src[p])) opnd[p] = fw_op[i][0:PKT_VAL_LSB];
        if (fwd_match(fw_ev[i], src[p])) opnd[p] = fw_ev[i][0:PKT_VAL_LSB];
      end
`endif
    end
  end

  // Output registers: clear on reset, hold on stall, else capture the pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_ra      <= '0;
      ev_rb      <= '0;
      ev_rc      <= '0;
      od_ra      <= '0;
      od_rb      <= '0;
      od_rc      <= '0;
      ev_rt_addr <= '0;
      od_rt_addr <= '0;
      ev_op_code <= NOP;
      od_op_code <= NOP;
      ev_I7      <= '0;
      ev_I10     <= '0;
      ev_I16     <= '0;
      ev_I18     <= '0;
      od_I7      <= '0;
      od_I10     <= '0;
      od_I16     <= '0;
      od_I18     <= '0;
      ev_valid   <= 1'b0;
      od_valid   <= 1'b0;
    end else if (!stall) begin
      ev_ra      <= opnd[0];
      ev_rb      <= opnd[1];
      ev_rc      <= opnd[2];
      od_ra      <= opnd[3];
      od_rb      <= opnd[4];
      od_rc      <= opnd[5];
      ev_rt_addr <= ev_rt_addr_in;
      od_rt_addr <= od_rt_addr_in;
      ev_op_code <= ev_valid_in ? ev_op_code_in : NOP;
      od_op_code <= od_valid_in ? od_op_code_in : NOP;
      ev_I7      <= ev_imm_in[11:17];
      ev_I10     <= ev_imm_in[8:17];
      ev_I16     <= ev_imm_in[2:17];
      ev_I18     <= ev_imm_in[0:17];
      od_I7      <= od_imm_in[11:17];
      od_I10     <= od_imm_in[8:17];
      od_I16     <= od_imm_in[2:17];
      od_I18     <= od_imm_in[0:17];
      ev_valid   <= ev_valid_in;
      od_valid   <= od_valid_in;
    end
  end

endmodule

// File: tb/tb_register_fetch_forward.sv
// Directed bench for register_fetch_forward with an expectation queue.
// Expected forwarding results follow REGFETCH_FWD_EN as compiled.
module tb_register_fetch_forward;
  import descriptions::*;

`ifdef REGFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int S_EV_RA = 0, S_EV_RB = 1, S_OD_RA = 2, S_OD_RB = 3;
  localparam int S_EV_VALID = 4, S_OD_VALID = 5, S_EV_OP = 6;
  localparam int S_EV_RT = 7, S_EV_I7 = 8, S_EV_I10 = 9;
  localparam int S_EV_I16 = 10, S_EV_I18 = 11, S_OD_OP = 12;

  typedef struct {
    string        tag;
    int           sel;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clock = 1'b0;
  logic reset, stall, ev_valid_in, od_valid_in;
  opcode ev_op_code_in, od_op_code_in;
  logic [6:0] ev_ra_addr, ev_rb_addr, ev_rc_addr;
  logic [6:0] od_ra_addr, od_rb_addr, od_rc_addr;
  logic [6:0] ev_rt_addr_in, od_rt_addr_in;
  logic [0:17] ev_imm_in, od_imm_in;
  logic [0:PKT_W-1] fw_ev [NUM_FW_STAGES];
  logic [0:PKT_W-1] fw_op [NUM_FW_STAGES];
  logic [0:PKT_W-1] wb_ev, wb_op;

  logic [127:0] ev_ra, ev_rb, ev_rc, od_ra, od_rb, od_rc;
  logic [6:0] ev_rt_addr, od_rt_addr;
  opcode ev_op_code, od_op_code;
  logic [6:0] ev_I7, od_I7;
  logic [9:0] ev_I10, od_I10;
  logic [15:0] ev_I16, od_I16;
  logic [17:0] ev_I18, od_I18;
  logic ev_valid, od_valid;

  always #5 clock = ~clock;

  register_fetch_forward dut (
    .clock(clock), .reset(reset), .stall(stall),
    .ev_valid_in(ev_valid_in), .od_valid_in(od_valid_in),
    .ev_op_code_in(ev_op_code_in), .od_op_code_in(od_op_code_in),
    .ev_ra_addr(ev_ra_addr), .ev_rb_addr(ev_rb_addr),
    .ev_rc_addr(ev_rc_addr), .od_ra_addr(od_ra_addr),
    .od_rb_addr(od_rb_addr), .od_rc_addr(od_rc_addr),
    .ev_rt_addr_in(ev_rt_addr_in), .od_rt_addr_in(od_rt_addr_in),
    .ev_imm_in(ev_imm_in), .od_imm_in(od_imm_in),
    .fw_ev_st_1(fw_ev[0]), .fw_ev_st_2(fw_ev[1]), .fw_ev_st_3(fw_ev[2]),
    .fw_ev_st_4(fw_ev[3]), .fw_ev_st_5(fw_ev[4]), .fw_ev_st_6(fw_ev[5]),
    .fw_ev_st_7(fw_ev[6]),
    .fw_op_st_1(fw_op[0]), .fw_op_st_2(fw_op[1]), .fw_op_st_3(fw_op[2]),
    .fw_op_st_4(fw_op[3]), .fw_op_st_5(fw_op[4]), .fw_op_st_6(fw_op[5]),
    .fw_op_st_7(fw_op[6]),
    .wb_ev(wb_ev), .wb_op(wb_op),
    .ev_ra(ev_ra), .ev_rb(ev_rb), .ev_rc(ev_rc),
    .od_ra(od_ra), .od_rb(od_rb), .od_rc(od_rc),
    .ev_rt_addr(ev_rt_addr), .od_rt_addr(od_rt_addr),
    .ev_op_code(ev_op_code), .od_op_code(od_op_code),
    .ev_I7(ev_I7), .ev_I10(ev_I10), .ev_I16(ev_I16), .ev_I18(ev_I18),
    .od_I7(od_I7), .od_I10(od_I10), .od_I16(od_I16), .od_I18(od_I18),
    .ev_valid(ev_valid), .od_valid(od_valid)
  );

  function automatic logic [0:PKT_W-1] mk(
    input logic [127:0] v, input logic [6:0] rt, input logic we
  );
    return {v, rt, we, 7'b0};
  endfunction

  function automatic logic [127:0] obs(input int sel);
    case (sel)
      S_EV_RA:    return ev_ra;
      S_EV_RB:    return ev_rb;
      S_OD_RA:    return od_ra;
      S_OD_RB:    return od_rb;
      S_EV_VALID: return {127'b0, ev_valid};
      S_OD_VALID: return {127'b0, od_valid};
      S_EV_OP:    return {120'b0, ev_op_code};
      S_OD_OP:    return {120'b0, od_op_code};
      S_EV_RT:    return {121'b0, ev_rt_addr};
      S_EV_I7:    return {121'b0, ev_I7};
      S_EV_I10:   return {118'b0, ev_I10};
      S_EV_I16:   return {112'b0, ev_I16};
      S_EV_I18:   return {110'b0, ev_I18};
      default:    return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [127:0] o;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_checks++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic clear_fw();
    for (int i = 0; i < NUM_FW_STAGES; i++) begin
      fw_ev[i] = '0;
      fw_op[i] = '0;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] imm;
    reset = 1'b1; stall = 1'b0;
    ev_valid_in = 1'b1; od_valid_in = 1'b1;
    ev_op_code_in = OP_ADD; od_op_code_in = OP_SUB;
    ev_ra_addr = 7'd5; ev_rb_addr = 7'd0; ev_rc_addr = 7'd0;
    od_ra_addr = 7'd0; od_rb_addr = 7'd0; od_rc_addr = 7'd0;
    ev_rt_addr_in = 7'd1; od_rt_addr_in = 7'd2;
    ev_imm_in = '0; od_imm_in = '0;
    wb_ev = '0; wb_op = '0;
    clear_fw();

    push("rst_ev_ra", S_EV_RA, 128'd0);
    push("rst_ev_valid", S_EV_VALID, 128'd0);
    push("rst_od_valid", S_OD_VALID, 128'd0);
    push("rst_ev_op", S_EV_OP, 128'(NOP));
    push("rst_od_op", S_OD_OP, 128'(NOP));
    tick();

    reset = 1'b0;
    imm = 18'h2ABCD;
    ev_imm_in = imm;
    push("post_rst_valid", S_EV_VALID, 128'd1);
    push("post_rst_ev_ra", S_EV_RA, 128'd0);
    push("post_rst_op", S_EV_OP, 128'(OP_ADD));
    push("imm_i7", S_EV_I7, 128'(imm & 18'h7F));
    push("imm_i10", S_EV_I10, 128'(imm & 18'h3FF));
    push("imm_i16", S_EV_I16, 128'(imm & 18'hFFFF));
    push("imm_i18", S_EV_I18, 128'(imm));
    tick();

    wb_ev = mk(128'd20, 7'd5, 1'b1);
    push("wb_ev_bypass", S_EV_RA, 128'd20);
    tick();

    wb_ev = '0;
    push("wb_ev_regfile", S_EV_RA, 128'd20);
    tick();

    wb_op = mk(128'hAAAA, 7'd9, 1'b1);
    od_rb_addr = 7'd9;
    push("wb_op_bypass", S_OD_RB, 128'hAAAA);
    push("od_valid_on", S_OD_VALID, 128'd1);
    tick();

    wb_op = '0;
    push("wb_op_regfile", S_OD_RB, 128'hAAAA);
    tick();

    fw_op[2] = mk(128'd99, 7'd7, 1'b1);
    fw_ev[4] = mk(128'd11, 7'd7, 1'b1);
    wb_ev = mk(128'd55, 7'd7, 1'b1);
    ev_ra_addr = 7'd7;
    push("fw_op3_over_ev5", S_EV_RA, FWD ? 128'd99 : 128'd55);
    tick();

    wb_ev = '0;
    fw_ev[2] = mk(128'd44, 7'd7, 1'b1);
    push("fw_ev3_over_op3", S_EV_RA, FWD ? 128'd44 : 128'd55);
    tick();

    clear_fw();
    push("wb_under_fw_stored", S_EV_RA, 128'd55);
    tick();

    ev_ra_addr = 7'd5; ev_rt_addr_in = 7'd3; ev_op_code_in = OP_ADD;
    push("pre_stall_ra", S_EV_RA, 128'd20);
    tick();

    stall = 1'b1;
    ev_ra_addr = 7'd9; ev_rt_addr_in = 7'd40;
    ev_op_code_in = OP_SUB; ev_valid_in = 1'b0;
    wb_ev = mk(128'h1234, 7'd12, 1'b1);
    push("stall1_ra", S_EV_RA, 128'd20);
    push("stall1_rt", S_EV_RT, 128'd3);
    push("stall1_valid", S_EV_VALID, 128'd1);
    tick();

    wb_ev = '0;
    ev_ra_addr = 7'd7;
    push("stall2_ra", S_EV_RA, 128'd20);
    push("stall2_op", S_EV_OP, 128'(OP_ADD));
    tick();

    ev_ra_addr = 7'd12;
    push("stall3_ra", S_EV_RA, 128'd20);
    tick();

    stall = 1'b0; ev_valid_in = 1'b1;
    push("post_stall_wb", S_EV_RA, 128'h1234);
    push("post_stall_op", S_EV_OP, 128'(OP_SUB));
    push("post_stall_rt", S_EV_RT, 128'd40);
    tick();

    ev_valid_in = 1'b0; ev_op_code_in = OP_ADD; ev_ra_addr = 7'd5;
    push("novalid_valid", S_EV_VALID, 128'd0);
    push("novalid_op_nop", S_EV_OP, 128'(NOP));
    push("novalid_ra", S_EV_RA, 128'd20);
    tick();

    ev_valid_in = 1'b1;
    wb_ev = mk(128'd1, 7'd3, 1'b1);
    wb_op = mk(128'd2, 7'd3, 1'b1);
    ev_ra_addr = 7'd3;
    push("dual_wb_bypass", S_EV_RA, 128'd1);
    tick();

    wb_ev = '0; wb_op = '0;
    fw_ev[0] = mk(128'd77, 7'd3, 1'b1);
    push("fw_ev1_r3", S_EV_RA, FWD ? 128'd77 : 128'd1);
    tick();

    clear_fw();
    od_ra_addr = 7'd3;
    push("dual_wb_stored", S_OD_RA, 128'd1);
    tick();

    wb_ev = mk(128'd5, 7'd20, 1'b0);
    ev_rb_addr = 7'd20;
    push("we0_bypass", S_EV_RB, 128'd0);
    tick();

    wb_ev = '0;
    push("we0_regfile", S_EV_RB, 128'd0);
    tick();

    reset = 1'b1; stall = 1'b1;
    wb_ev = mk(128'd66, 7'd5, 1'b1);
    push("midrst_valid", S_EV_VALID, 128'd0);
    push("midrst_op", S_EV_OP, 128'(NOP));
    push("midrst_ra", S_EV_RA, 128'd0);
    tick();

    reset = 1'b0; stall = 1'b0; wb_ev = '0;
    ev_ra_addr = 7'd5;
    push("midrst_rf_clear", S_EV_RA, 128'd0);
    push("midrst_resume", S_EV_VALID, 128'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_fetch_forward.md
# register_fetch_forward

Operand-fetch stage sitting directly upstream of the even and odd pipes. It holds the 128 x 128-bit register file and, for each dual-issued instruction pair, reads ra/rb/rc and resolves hazards against the seven in-flight stage packets of both pipes. It also writes back the final-stage packets. The resolved operands, rt address, opcode and immediates are registered and presented to the pipes one cycle later.

## Interface
- NUM_REGS, 128, architectural register count (address width 7).
- NUM_FW_STAGES, 7, forwarding packets per pipe (fw_*_st_1..7).
- PKT_W, 143, stage packet width: [0:127] value, [128:134] rt address, [135] write enable, [136:142] reserved (ignored).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all output registers; input fields are ignored this cycle.
- ev_valid_in / od_valid_in  in  1  instruction present on that pipe's decode fields.
- ev_op_code_in / od_op_code_in  in  opcode  decoded opcode; passed through.
- ev_ra_addr / ev_rb_addr / ev_rc_addr (and od_*)  in  7 each  source register addresses.
- ev_rt_addr_in / od_rt_addr_in  in  7  destination; passed through.
- ev_imm_in / od_imm_in  in  18  raw immediate field; passed through as slices.
- fw_ev_st_1..7 / fw_op_st_1..7  in  PKT_W each  in-flight packets; st_1 is youngest.
- wb_ev / wb_op  in  PKT_W each  retiring packets to write into the register file.
- ev_ra / ev_rb / ev_rc (and od_*)  out  128 each  resolved operands.
- ev_rt_addr / od_rt_addr  out  7; ev_op_code / od_op_code  out  opcode.
- ev_I7/I10/I16/I18 (and od_*)  out  7/10/16/18  imm[11:17], imm[8:17], imm[2:17], imm[0:17].
- ev_valid / od_valid  out  1  output fields are valid.

## Operation
- Read: six combinational reads of the register file. ra/rb/rc are read for each pipe.
- Resolution order for each source operand, first match wins:
  1. fw_ev_st_1
  2. fw_op_st_1
  3. fw_ev_st_2
  4. fw_op_st_2
  5. continue alternating in the same pattern up to st_7
  6. wb_ev
  7. wb_op
  8. register file
- A packet matches only if bit 135 = 1 and bits [128:134] equal the source address.
- Write-back: when bit 135 = 1, wb_ev and wb_op write value [0:127] to address [128:134] on the rising edge. If both packets target the same address, wb_ev's value is stored.
- Register 0 is not special. All 128 registers are writable and forwardable.
- An output with valid-in = 0 still registers its fields, and its valid bit goes 0. Its opcode output is forced to the package NOP code.
- No intra-pair hazard check: the odd instruction never sees the even instruction of the same pair. The issue logic guarantees independence.

## Timing
- Latency: 1 cycle from the decode fields to the registered outputs. Write-back is visible to a same-cycle read through the wb bypass, and from the register file on the next cycle.
- Stall:
  - Output registers hold their values.
  - Write-back still occurs; retiring packets are never dropped.
  - On the cycle stall deasserts, the fields present that cycle are captured. Replaying them is the issue logic's job.
- Reset:
  - Clears every register to 0.
  - Clears all outputs to 0; both valid bits = 0, both opcodes = NOP.
  - Takes priority over stall and write-back in the same cycle.
  - Reset mid-stream discards the in-flight pair.
- Simultaneous events: a matching forward packet overrides a same-address write-back for the read result. Write-back still updates the register file.

## Configuration
- REGFETCH_FWD_EN defined: full resolution over the fw_*_st_1..7 packets as above.
- REGFETCH_FWD_EN undefined: the fw_* ports remain on the interface but are ignored. Resolution is wb_ev, then wb_op, then the register file. The issue logic must then stall on hazards.

## Structure
- Package descriptions (existing) holds `opcode` and NOP.
- Add to the same package:
  - constants NUM_REGS, NUM_FW_STAGES and PKT_W;
  - bit-slice constants PKT_VAL_LSB = 127, PKT_RT_MSB = 128, PKT_RT_LSB = 134, PKT_WE = 135;
  - a function `fwd_match(pkt, addr)`.
- Sub-module register_file_2w6r: the storage, two write ports with even priority, six asynchronous read ports, and synchronous reset.
- The top level holds the forwarding muxes and output registers.

## Test plan
- Reset, then read r5 on ev_ra → ev_ra = 0 and ev_valid = 0 during reset. After reset: ev_valid = 1, ev_ra = 0.
- wb_ev = {value 128'd20, rt 5, we 1}. Next cycle, read r5 with all fw packets idle → ev_ra = 20.
- wb_op writes r9 = 0xAAAA. In the same cycle, read r9 on od_rb → od_rb = 0xAAAA (bypass). The register file holds 0xAAAA afterwards.
- fw_op_st_3 = {99, rt 7, we 1} and fw_ev_st_5 = {11, rt 7, we 1}, read r7 → 99. Repeat with fw_ev_st_3 also = {44, rt 7} → 44.
- Stall held for 3 cycles while the decode fields change → outputs frozen. A wb write to r12 issued during the stall is readable after stall deasserts.
- wb_ev and wb_op both write r3 (value 1 and value 2) → r3 = 1. With REGFETCH_FWD_EN undefined, fw_ev_st_1 = {77, rt 3} is ignored → ev_ra = 1.
